// File: rtl/soc_pkg.sv
// Shared types and the scalar compare used by the comparator arbiter.
package soc_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic equal;
        logic less;
        logic greater;
    } cmp_flags_t;

    localparam int CMP_EQ_BIT = 2;
    localparam int CMP_LT_BIT = 1;
    localparam int CMP_GT_BIT = 0;

    function automatic logic [2:0] compare(input data_t a, input data_t b);
        logic [2:0] r;
        r             = '0;
        r[CMP_EQ_BIT] = (a == b);
        r[CMP_LT_BIT] = (a < b);
        r[CMP_GT_BIT] = (a > b);
        return r;
    endfunction

endpackage

// File: rtl/cmp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;

    always_comb begin
        logic [IW-1:0] jj;
        found   = 1'b0;
        gnt_idx = '0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            jj = IW'((int'(ptr) + k) % N);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt_idx = jj;
            end
        end
        gnt = '0;
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one comparator among NUM_REQ valid/ready requesters.
module cmp_arbiter
    import soc_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  data_t [NUM_REQ-1:0]   req_a,
    input  data_t [NUM_REQ-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_equal,
    output logic                  rsp_less,
    output logic                  rsp_greater,
    output logic [15:0]           cmp_count
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    cmp_flags_t      flags_q, flags_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [15:0]     count_q, count_d;

    logic            can_accept;
    logic [ID_W-1:0] gnt_idx;
    logic            xfer;
    data_t           op_a, op_b;
    cmp_flags_t      cmp_res;

    assign can_accept = !rsp_valid_q || rsp_ready;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (can_accept && !rst),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign xfer    = |req_ready;
    assign op_a    = req_a[gnt_idx];
    assign op_b    = req_b[gnt_idx];
    assign cmp_res = cmp_flags_t'(compare(op_a, op_b));

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        flags_d     = flags_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            flags_d     = cmp_res;
            count_d     = count_q + 16'd1;
            if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end else if (rsp_ready) begin
            // id and flags keep their last values after a drain
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            flags_q     <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            flags_q     <= flags_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_equal   = flags_q.equal;
    assign rsp_less    = flags_q.less;
    assign rsp_greater = flags_q.greater;
    assign cmp_count   = count_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: random traffic plus directed scenarios.
module tb_cmp_arbiter;
    import soc_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    data_t [N-1:0] req_a;
    data_t [N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic          rsp_equal;
    logic          rsp_less;
    logic          rsp_greater;
    logic [15:0]   cmp_count;

    cmp_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_equal   (rsp_equal),
        .rsp_less    (rsp_less),
        .rsp_greater (rsp_greater),
        .cmp_count   (cmp_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] id;
        logic [2:0] flags;
    } exp_t;

    exp_t        sb[$];
    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    int          m_count = 0;
    bit          armed   = 1'b0;
    logic [N-1:0] last_xfer = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: scan from pointer for the first valid requester, queue a/b relation.
    always @(negedge clk) begin
        int         g;
        logic [1:0] ix;
        logic [N-1:0] er;
        exp_t       e;
        if (armed) begin
            g = -1;
            if (!rst && (!m_valid || rsp_ready)) begin
                for (int k = 0; k < N; k++) begin
                    ix = 2'((m_ptr + k) % N);
                    if (g < 0 && req_valid[ix]) g = (m_ptr + k) % N;
                end
            end
            er = '0;
            if (g >= 0) er[2'(g)] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("cmp_count", 32'(cmp_count), 32'(m_count));
            last_xfer = req_valid & req_ready;
            if (rsp_valid)
                chk("one_flag", $countones({rsp_equal, rsp_less, rsp_greater}), 1);
            if (!rst && m_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_flags", 32'({rsp_equal, rsp_less, rsp_greater}), 32'(e.flags));
                end
            end
            if (rst) begin
                sb.delete();
                m_ptr   = 0;
                m_valid = 1'b0;
                m_count = 0;
            end else if (g >= 0) begin
                ix      = 2'(g);
                e.id    = ix;
                e.flags = {req_a[ix] == req_b[ix], req_a[ix] < req_b[ix],
                           req_a[ix] > req_b[ix]};
                sb.push_back(e);
                m_ptr   = (g + 1) % N;
                m_count = (m_count + 1) % 65536;
                m_valid = 1'b1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic data_t rnd();
        if ($urandom_range(0, 2) != 0) return data_t'($urandom_range(0, 7));
        return data_t'($urandom);
    endfunction

    initial begin
        logic [N-1:0] eo;
        logic [15:0]  wrap_exp [3];
        wrap_exp[0] = 16'hFFFF;
        wrap_exp[1] = 16'h0000;
        wrap_exp[2] = 16'h0001;

        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int r = 0; r < N; r++) begin
            req_a[r] = rnd();
            req_b[r] = rnd();
        end
        step();
        armed = 1'b1;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] || last_xfer[r]) begin
                    req_valid[r] = ($urandom_range(0, 99) < 60);
                    req_a[r]     = rnd();
                    req_b[r]     = rnd();
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("sb_empty_random", 32'(sb.size()), 0);

        // single requester
        req_valid = 4'b0100;
        req_a[2]  = 16'd5;
        req_b[2]  = 16'd9;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 2);
        chk("single_flags", 32'({rsp_equal, rsp_less, rsp_greater}), 32'h2);

        // round robin from a fresh pointer
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = '1;
        for (int r = 0; r < N; r++) begin
            req_a[r] = 16'd7;
            req_b[r] = 16'd7;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            eo = 4'b0001 << (k % 4);
            chk("rr_order", 32'(req_ready), 32'(eo));
            step();
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_count", 32'(cmp_count), 8);

        // backpressure then back-to-back accept
        req_valid = 4'b0010;
        req_a[1]  = 16'd9;
        req_b[1]  = 16'd3;
        step();
        req_valid = 4'b0100;
        req_a[2]  = 16'd1;
        req_b[2]  = 16'd1;
        rsp_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_flags", 32'({rsp_equal, rsp_less, rsp_greater}), 32'h1);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(rsp_valid), 1);
        chk("b2b_id", 32'(rsp_id), 2);
        chk("b2b_flags", 32'({rsp_equal, rsp_less, rsp_greater}), 32'h4);

        // reset with a pending result and pointer at 3
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(rsp_valid), 0);
        chk("midrst_ready", 32'(req_ready), 32'h1);
        chk("midrst_count", 32'(cmp_count), 0);

        // counter wrap
        repeat (65534) step();
        @(negedge clk);
        chk("wrap_fffe", 32'(cmp_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("wrap_seq", 32'(cmp_count), 32'(wrap_exp[k]));
        end
        req_valid = '0;
        repeat (3) step();
        chk("sb_empty_end", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
